// File: rtl/store_mem_sequencer_pkg.sv
// Shared encodings for the store/load memory sequencer: store widths, FSM states
// and the store alignment check.
package store_mem_sequencer_pkg;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_BYTE = 2'b01;
    localparam logic [1:0] ST_HALF = 2'b10;
    localparam logic [1:0] ST_RSVD = 2'b11;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ISSUE = 3'd1;
    localparam logic [2:0] S_RD_WAIT  = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;

    // Byte stores may land on any lane; halves need even, words need 4-byte alignment.
    function automatic logic store_error(input logic [1:0] st, input logic [1:0] lo);
        return (st == ST_RSVD) ||
               ((st == ST_HALF) && lo[0]) ||
               ((st == ST_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/store_mem_sequencer_if.sv
// Request/response handshake with the core plus the single-port RAM bus.
interface store_mem_sequencer_if;

    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] Addr;
    logic [1:0]  StoreType;
    logic [31:0] rd2;
    logic        RespValid;
    logic        RespErr;
    logic [31:0] RespData;
    logic        MemEn;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    modport slave (
        input  ReqValid, ReqWrite, Addr, StoreType, rd2, MemRData,
        output ReqReady, RespValid, RespErr, RespData,
               MemEn, MemWe, MemAddr, MemWData
    );

    modport master (
        output ReqValid, ReqWrite, Addr, StoreType, rd2, MemRData,
        input  ReqReady, RespValid, RespErr, RespData,
               MemEn, MemWe, MemAddr, MemWData
    );

endinterface

// File: rtl/store_mem_sequencer_write_data.sv
// Store-merge logic: replaces the addressed byte or half-word lanes of the old
// RAM word with the low bits of the store value.
module write_data
    import store_mem_sequencer_pkg::*;
(
    input  logic [31:0] ReadData,
    input  logic [31:0] rd2,
    input  logic [1:0]  Addr,
    input  logic [1:0]  StoreType,
    output logic [31:0] WriteData
);

    always_comb begin
        WriteData = ReadData;
        case (StoreType)
            ST_WORD: WriteData = rd2;
            ST_BYTE: WriteData[{Addr, 3'b000} +: 8] = rd2[7:0];
            ST_HALF: WriteData[{Addr[1], 4'b0000} +: 16] = rd2[15:0];
            default: WriteData = ReadData;
        endcase
    end

endmodule

// File: rtl/store_mem_sequencer.sv
// Memory-stage sequencer: word loads, direct word stores and read-modify-write
// byte/half stores against a single-port synchronous RAM.
module store_mem_sequencer
    import store_mem_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    store_mem_sequencer_if.slave bus
);

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_rd2;
    logic [31:0] r_old_word;
    logic [1:0]  r_store_type;
    logic        r_write;
    logic        r_err;

    logic        w_ready;
    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_merged;
    logic [31:0] w_store_word;

    assign w_ready   = (r_state == S_IDLE) && !reset;
    assign w_accept  = bus.ReqValid && w_ready;
    assign w_req_err = bus.ReqWrite && store_error(bus.StoreType, bus.Addr[1:0]);

    write_data u_write_data (
        .ReadData  (r_old_word),
        .rd2       (r_rd2),
        .Addr      (r_addr[1:0]),
        .StoreType (r_store_type),
        .WriteData (w_merged)
    );

    // Word stores bypass the merge so they never depend on a stale OldWord.
    assign w_store_word = (r_store_type == ST_WORD) ? r_rd2 : w_merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_rd2        <= '0;
            r_old_word   <= '0;
            r_store_type <= ST_WORD;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= bus.Addr;
                        r_rd2        <= bus.rd2;
                        r_store_type <= bus.StoreType;
                        r_write      <= bus.ReqWrite;
                        r_err        <= w_req_err;
                        if (w_req_err)
                            r_state <= S_RESP;
                        else if (bus.ReqWrite && (bus.StoreType == ST_WORD))
                            r_state <= S_WR;
                        else
                            r_state <= S_RD_ISSUE;
                    end
                end
                S_RD_ISSUE: r_state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    r_old_word <= bus.MemRData;
                    r_state    <= r_write ? S_WR : S_RESP;
                end
                S_WR:    r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode from state and latched registers; reset forces them to 0.
    assign bus.ReqReady  = w_ready;
    assign bus.RespValid = (r_state == S_RESP);
    assign bus.RespErr   = (r_state == S_RESP) && r_err;
    assign bus.RespData  = ((r_state == S_RESP) && !r_err) ?
                           (r_write ? w_store_word : r_old_word) : 32'h0;
    assign bus.MemEn     = (r_state == S_RD_ISSUE) || (r_state == S_WR);
    assign bus.MemWe     = (r_state == S_WR);
    assign bus.MemAddr   = {r_addr[31:2], 2'b00};
    assign bus.MemWData  = (r_state == S_WR) ? w_store_word : 32'h0;

endmodule

// File: tb/tb_store_mem_sequencer.sv
// Bench for store_mem_sequencer: vector table through a response scoreboard plus
// hand-written reset corner cases, against a behavioural synchronous RAM.
module tb_store_mem_sequencer;

    localparam logic [31:0] BG = 32'ha5b4c3d2;

    typedef struct {
        logic        wr;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] rd2;
        int          lat;
        logic        err;
        logic [31:0] data;
        int          reads;
        int          writes;
        logic [31:0] mem_after;
    } vec_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] data;
        int          rd0;
        int          wr0;
        int          reads;
        int          writes;
        logic [31:0] wdata;
    } exp_t;

    logic clk;
    logic reset;
    logic bg_load;

    store_mem_sequencer_if bus ();

    store_mem_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [31:0] mem [0:3];
    logic [31:0] last_wdata;
    int          n_rd;
    int          n_wr;
    int          n_b2b;
    logic        prev_en;

    initial begin
        n_rd = 0;
        n_wr = 0;
        n_b2b = 0;
        prev_en = 1'b0;
        last_wdata = '0;
        bus.MemRData = '0;
    end

    always @(posedge clk) begin
        if (bg_load)
            mem[0] <= BG;
        else if (bus.MemEn && bus.MemWe) begin
            mem[bus.MemAddr[3:2]] <= bus.MemWData;
            last_wdata <= bus.MemWData;
            n_wr <= n_wr + 1;
        end
        if (bus.MemEn && !bus.MemWe) begin
            bus.MemRData <= mem[bus.MemAddr[3:2]];
            n_rd <= n_rd + 1;
        end
        if (bus.MemEn && prev_en)
            n_b2b <= n_b2b + 1;
        prev_en <= bus.MemEn;
    end

    int   checks;
    int   failures;
    vec_t vecs [13];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic load_bg();
        @(negedge clk);
        bg_load = 1'b1;
        @(negedge clk);
        bg_load = 1'b0;
    endtask

    task automatic drive(input logic wr, input logic [1:0] st, input logic [31:0] addr,
                         input logic [31:0] rd2);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = wr;
        bus.StoreType = st;
        bus.Addr      = addr;
        bus.rd2       = rd2;
        @(posedge clk);
        #1;
        bus.ReqValid  = 1'b0;
    endtask

    initial begin
        exp_t e;
        bit   seen;
        int   rd0;
        int   wr0;

        checks = 0;
        failures = 0;
        reset = 1'b1;
        bg_load = 1'b0;
        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.StoreType = 2'b00;
        bus.Addr = '0;
        bus.rd2 = '0;

        vecs[0]  = '{1'b0, 2'b00, 32'h2, 32'hffffffff, 3, 1'b0, 32'ha5b4c3d2, 1, 0, 32'ha5b4c3d2};
        vecs[1]  = '{1'b1, 2'b01, 32'h1, 32'hffffffff, 4, 1'b0, 32'ha5b4ffd2, 1, 1, 32'ha5b4ffd2};
        vecs[2]  = '{1'b1, 2'b10, 32'h2, 32'hffffffff, 4, 1'b0, 32'hffffc3d2, 1, 1, 32'hffffc3d2};
        vecs[3]  = '{1'b1, 2'b00, 32'h0, 32'hffffffff, 2, 1'b0, 32'hffffffff, 0, 1, 32'hffffffff};
        vecs[4]  = '{1'b1, 2'b10, 32'h3, 32'hffffffff, 1, 1'b1, 32'h0,        0, 0, 32'ha5b4c3d2};
        vecs[5]  = '{1'b1, 2'b11, 32'h0, 32'hffffffff, 1, 1'b1, 32'h0,        0, 0, 32'ha5b4c3d2};
        vecs[6]  = '{1'b1, 2'b00, 32'h2, 32'hffffffff, 1, 1'b1, 32'h0,        0, 0, 32'ha5b4c3d2};
        vecs[7]  = '{1'b1, 2'b01, 32'h3, 32'hffffffff, 4, 1'b0, 32'hffb4c3d2, 1, 1, 32'hffb4c3d2};
        vecs[8]  = '{1'b1, 2'b10, 32'h0, 32'hffffffff, 4, 1'b0, 32'ha5b4ffff, 1, 1, 32'ha5b4ffff};
        vecs[9]  = '{1'b1, 2'b01, 32'h0, 32'h12345678, 4, 1'b0, 32'ha5b4c378, 1, 1, 32'ha5b4c378};
        vecs[10] = '{1'b1, 2'b10, 32'h2, 32'h12345678, 4, 1'b0, 32'h5678c3d2, 1, 1, 32'h5678c3d2};
        vecs[11] = '{1'b0, 2'b11, 32'h1, 32'hffffffff, 3, 1'b0, 32'ha5b4c3d2, 1, 0, 32'ha5b4c3d2};
        vecs[12] = '{1'b1, 2'b01, 32'h2, 32'hffffffff, 4, 1'b0, 32'ha5ffc3d2, 1, 1, 32'ha5ffc3d2};

        // Reset state
        @(negedge clk);
        chk("rst_ReqReady",  {31'b0, bus.ReqReady},  32'h0);
        chk("rst_RespValid", {31'b0, bus.RespValid}, 32'h0);
        chk("rst_RespErr",   {31'b0, bus.RespErr},   32'h0);
        chk("rst_RespData",  bus.RespData,           32'h0);
        chk("rst_MemEn",     {31'b0, bus.MemEn},     32'h0);
        chk("rst_MemWe",     {31'b0, bus.MemWe},     32'h0);
        chk("rst_MemAddr",   bus.MemAddr,            32'h0);
        chk("rst_MemWData",  bus.MemWData,           32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ReqReady", {31'b0, bus.ReqReady}, 32'h1);

        for (int i = 0; i < 13; i++) begin
            load_bg();
            e.lat    = vecs[i].lat;
            e.err    = vecs[i].err;
            e.data   = vecs[i].data;
            e.rd0    = n_rd;
            e.wr0    = n_wr;
            e.reads  = vecs[i].reads;
            e.writes = vecs[i].writes;
            e.wdata  = vecs[i].mem_after;
            drive(vecs[i].wr, vecs[i].st, vecs[i].addr, vecs[i].rd2);
            sb.push_back(e);
            chk($sformatf("v%0d_busy_ReqReady", i), {31'b0, bus.ReqReady}, 32'h0);
            seen = 1'b0;
            for (int k = 1; k <= 8 && !seen; k++) begin
                @(negedge clk);
                if (bus.RespValid) begin
                    seen = 1'b1;
                    e = sb.pop_front();
                    chk($sformatf("v%0d_latency", i), k, e.lat);
                    chk($sformatf("v%0d_RespErr", i), {31'b0, bus.RespErr}, {31'b0, e.err});
                    chk($sformatf("v%0d_RespData", i), bus.RespData, e.data);
                    chk($sformatf("v%0d_reads", i), n_rd - e.rd0, e.reads);
                    chk($sformatf("v%0d_writes", i), n_wr - e.wr0, e.writes);
                    if (e.writes > 0)
                        chk($sformatf("v%0d_MemWData", i), last_wdata, e.wdata);
                end
            end
            if (!seen) begin
                checks++;
                failures++;
                $display("FAIL v%0d_resp_timeout: no RespValid within 8 cycles", i);
                void'(sb.pop_front());
            end
            @(negedge clk);
            chk($sformatf("v%0d_resp_pulse", i), {31'b0, bus.RespValid}, 32'h0);
            chk($sformatf("v%0d_ram", i), mem[0], vecs[i].mem_after);
        end

        // Reset during RD_WAIT of a byte store
        load_bg();
        rd0 = n_rd;
        wr0 = n_wr;
        drive(1'b1, 2'b01, 32'h1, 32'hffffffff);
        @(negedge clk);
        chk("rwait_issue_MemEn", {31'b0, bus.MemEn}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rwait_rst_MemEn",    {31'b0, bus.MemEn},    32'h0);
        chk("rwait_rst_MemWe",    {31'b0, bus.MemWe},    32'h0);
        chk("rwait_rst_ReqReady", {31'b0, bus.ReqReady}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        chk("rwait_ReqReady", {31'b0, bus.ReqReady}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (bus.RespValid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rwait_no_resp", {31'b0, seen}, 32'h0);
        chk("rwait_reads",   n_rd - rd0, 32'd1);
        chk("rwait_writes",  n_wr - wr0, 32'd0);
        chk("rwait_ram",     mem[0], BG);

        // Reset during RD_ISSUE: the read strobe must vanish before the edge
        rd0 = n_rd;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        chk("rissue_MemEn", {31'b0, bus.MemEn}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rissue_rst_MemEn", {31'b0, bus.MemEn}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.RespValid) seen = 1'b1;
        end
        chk("rissue_no_resp", {31'b0, seen}, 32'h0);
        chk("rissue_reads",   n_rd - rd0, 32'd0);
        chk("rissue_ram",     mem[0], BG);

        chk("no_back_to_back_MemEn", n_b2b, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_mem_sequencer.md
# store_mem_sequencer

Sequencing stage between the core's memory-stage request and a single-port synchronous data RAM. It issues word loads and performs stores. Word stores go straight to the RAM. Byte and half-word stores run as read-modify-write: the block reads the old word, merges the new lanes into it, and writes the merged word back. It is the consumer of the existing store-merge logic and owns all RAM handshaking and timing.

## Interface
- No parameters; data and address widths are fixed at 32.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- ReqValid  in  1  request present
- ReqReady  out  1  high only in IDLE and while reset is low
- ReqWrite  in  1  1 = store, 0 = load
- Addr  in  32  byte address
- StoreType  in  2  00 word, 01 byte, 10 half, 11 reserved; ignored for loads
- rd2  in  32  store value; byte uses [7:0], half uses [15:0]
- RespValid  out  1  one-cycle completion pulse; no backpressure
- RespErr  out  1  valid with RespValid; misaligned or reserved store
- RespData  out  32  load: word read; store: word written; error: 0
- MemEn  out  1  RAM access this cycle
- MemWe  out  1  write when MemEn is high
- MemAddr  out  32  {Addr[31:2], 2'b00}
- MemWData  out  32  write data, valid when MemEn and MemWe are high
- MemRData  in  32  read data, valid the cycle after a read-enable cycle

## Operation
- Request is accepted when ReqValid and ReqReady are both high at a clk edge. The block latches Addr, rd2, StoreType and ReqWrite.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR, RESP.
- Transitions out of IDLE on accept:
  - error store → RESP
  - word store → WR
  - load or byte/half store → RD_ISSUE
- RD_ISSUE: MemEn=1, MemWe=0. Next state is RD_WAIT.
- RD_WAIT: MemRData is registered into OldWord. A load goes to RESP; a byte/half store goes to WR.
- WR: MemEn=1, MemWe=1. Next state is RESP.
  - Word store: MemWData = rd2.
  - Byte store: MemWData = OldWord with lane Addr[1:0] replaced by rd2[7:0].
  - Half store: MemWData = OldWord with half Addr[1] replaced by rd2[15:0].
- RESP: RespValid=1, then return to IDLE. A new request is accepted no earlier than the cycle after RESP.
- Error conditions, checked on stores only:
  - StoreType 11
  - half store with Addr[0]=1
  - word store with Addr[1:0]≠00
- On error there is no RAM access, RespErr=1 and RespData=0.
- Loads never error; lane extraction happens downstream.
- All outputs are Moore outputs decoded from the state and latched registers.

## Timing
- Accept edge T; RespValid is high in the cycle that begins at:
  - T+1 for an error store
  - T+2 for a word store
  - T+3 for a load
  - T+4 for a byte or half store
- MemEn pulses exactly once per read or write phase. There are never back-to-back accesses within one transaction.
- Reset values while reset is high: state IDLE, ReqReady=0, and the following all 0: RespValid, RespErr, RespData, MemEn, MemWe, MemAddr, MemWData, OldWord.
- ReqReady rises in the first cycle after reset deasserts.
- Reset mid-transaction abandons the transaction and drops MemEn/MemWe asynchronously.
  - Reset in RD_ISSUE or RD_WAIT leaves the RAM unmodified.
  - Reset in WR may leave the write either applied or not applied, depending on edge alignment; the bench does not check this case.
- ReqValid while not in IDLE is ignored; the requester must hold it until accepted.
- Address wrap is not applicable; MemAddr is a pure mask of Addr.

## Structure
- Shared package defines:
  - StoreType encodings: ST_WORD=2'b00, ST_BYTE=2'b01, ST_HALF=2'b10, ST_RSVD=2'b11
  - FSM state encoding
- The merge instantiates the existing write_data module as the single sub-module. Its inputs are OldWord as ReadData, latched rd2, latched Addr and latched StoreType; its WriteData output is used for byte/half stores only.

## Test plan
- Background for all scenarios: RAM word at 0x0 = 0xa5b4c3d2, rd2 = 0xffffffff.
- Load Addr 0x2:
  - one read of MemAddr 0x0, no write
  - RespValid at T+3 with RespData 0xa5b4c3d2 and RespErr=0
- Byte store Addr 0x1:
  - read then write of MemWData 0xa5b4ffd2
  - RespValid at T+4 with RespData 0xa5b4ffd2
- Half store Addr 0x2:
  - MemWData 0xffffc3d2, RespValid at T+4
- Word store Addr 0x0:
  - no read; single write 0xffffffff; RespValid at T+2
- Error stores (half at Addr 0x3, StoreType 11):
  - no MemEn; RespErr=1 and RespData=0 at T+1
- Assert reset in RD_WAIT of a byte store:
  - MemEn drops immediately; RAM word still 0xa5b4c3d2
  - ReqReady returns 1 one cycle after reset release; no RespValid is issued
